// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator; advances one step per DACLRC sample and drives one mixer gain input.
// Define ADSR_EXP_RELEASE_EN for exponential decay/release; the default build uses linear ramps.
module adsr_envelope #(
  parameter int                 BITSIZE   = 24,
  parameter logic [BITSIZE-1:0] LEVEL_MAX = {1'b0, {(BITSIZE-1){1'b1}}}
) (
  input  logic               lrclk,
  input  logic               reset,
  input  logic               gate,
  input  logic [BITSIZE-1:0] attack_step,
  input  logic [BITSIZE-1:0] decay_step,
  input  logic [BITSIZE-1:0] sustain_level,
  input  logic [BITSIZE-1:0] release_step,
  output logic [BITSIZE-1:0] out,
  output logic               active,
  output logic               done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

`ifdef ADSR_EXP_RELEASE_EN
  localparam logic signed [BITSIZE:0] ONE = {{BITSIZE{1'b0}}, 1'b1};
`endif

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic               gate_d;
  logic               rise;
  logic               fall;
  logic [BITSIZE-1:0] sus;
  logic [BITSIZE-1:0] out_nx;
  logic               done_nx;

  // Rising ramp, saturating at LEVEL_MAX; a zero step jumps straight to the peak.
  function automatic logic [BITSIZE-1:0] attack_next(input logic [BITSIZE-1:0] lvl,
                                                     input logic [BITSIZE-1:0] step);
    logic [BITSIZE:0] sum;
    sum = {1'b0, lvl} + {1'b0, step};
    if (step == '0 || sum >= {1'b0, LEVEL_MAX}) attack_next = LEVEL_MAX;
    else attack_next = sum[BITSIZE-1:0];
  endfunction

  // Falling ramp, floored at target; the result equals target exactly when the ramp has ended.
  function automatic logic [BITSIZE-1:0] fall_next(input logic [BITSIZE-1:0] lvl,
                                                   input logic [BITSIZE-1:0] step,
                                                   input logic [BITSIZE-1:0] target);
    logic signed [BITSIZE:0] cur;
    logic signed [BITSIZE:0] tgt;
    logic signed [BITSIZE:0] dec;
    logic signed [BITSIZE:0] diff;
    cur = signed'({1'b0, lvl});
    tgt = signed'({1'b0, target});
`ifdef ADSR_EXP_RELEASE_EN
    dec = ((cur - tgt) >>> step[4:0]) + ONE;
`else
    dec = signed'({1'b0, step});
`endif
    diff = cur - dec;
    if (step == '0 || diff <= tgt) fall_next = target;
    else fall_next = diff[BITSIZE-1:0];
  endfunction

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;
  assign sus  = (sustain_level > LEVEL_MAX) ? LEVEL_MAX : sustain_level;

  always_comb begin
    state_nx = state;
    out_nx   = out;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        out_nx = '0;
        if (rise) state_nx = ATTACK;
      end
      ATTACK: begin
        if (fall) state_nx = RELEASE;
        else begin
          out_nx = attack_next(out, attack_step);
          if (out_nx == LEVEL_MAX) state_nx = DECAY;
        end
      end
      DECAY: begin
        if (fall) state_nx = RELEASE;
        else begin
          out_nx = fall_next(out, decay_step, sus);
          if (out_nx == sus) state_nx = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (fall) state_nx = RELEASE;
        else out_nx = sus;
      end
      RELEASE: begin
        // Retrigger resumes the attack from the current level rather than from zero.
        if (rise) state_nx = ATTACK;
        else begin
          out_nx = fall_next(out, release_step, '0);
          if (out_nx == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        out_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge lrclk) begin
    if (reset) begin
      state  <= IDLE;
      gate_d <= 1'b0;
      out    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      gate_d <= gate;
      out    <= out_nx;
      active <= (state_nx != IDLE);
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ramp scenarios plus randomized gate/step traffic.
module tb_adsr_envelope;

  logic        lrclk = 1'b0;
  logic        reset;
  logic        gate;
  logic [23:0] attack_step;
  logic [23:0] decay_step;
  logic [23:0] sustain_level;
  logic [23:0] release_step;
  logic [23:0] out;
  logic        active;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  adsr_envelope #(.BITSIZE(24)) dut (
    .lrclk(lrclk), .reset(reset), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .out(out), .active(active), .done(done)
  );

  always #5 lrclk = ~lrclk;

  // Reference model: envelope phase plus level as plain integers.
  typedef enum {M_OFF, M_UP, M_DOWN, M_HOLD, M_FADE} phase_t;
  localparam longint MAXL = 64'h7FFFFF;
  phase_t ph    = M_OFF;
  longint lvl   = 0;
  bit     gprev = 1'b0;
  bit     e_act = 1'b0;
  bit     e_done = 1'b0;

  function automatic longint fade(input longint cur, input longint st, input longint tgt);
    longint d;
`ifdef ADSR_EXP_RELEASE_EN
    d = ((cur - tgt) >>> (st & 31)) + 1;
`else
    d = st;
`endif
    if (st == 0 || cur - d <= tgt) return tgt;
    return cur - d;
  endfunction

  task automatic model_edge();
    bit rise;
    bit fall;
    longint s;
    longint a;
    if (reset) begin
      ph = M_OFF; lvl = 0; gprev = 0; e_act = 0; e_done = 0;
      return;
    end
    rise = gate && !gprev;
    fall = !gate && gprev;
    s = (longint'(sustain_level) > MAXL) ? MAXL : longint'(sustain_level);
    a = longint'(attack_step);
    e_done = 0;
    case (ph)
      M_OFF: begin lvl = 0; if (rise) ph = M_UP; end
      M_UP: begin
        if (fall) ph = M_FADE;
        else if (a == 0 || lvl + a >= MAXL) begin lvl = MAXL; ph = M_DOWN; end
        else lvl = lvl + a;
      end
      M_DOWN: begin
        if (fall) ph = M_FADE;
        else begin
          lvl = fade(lvl, longint'(decay_step), s);
          if (lvl == s) ph = M_HOLD;
        end
      end
      M_HOLD: begin
        if (fall) ph = M_FADE;
        else lvl = s;
      end
      M_FADE: begin
        if (rise) ph = M_UP;
        else begin
          lvl = fade(lvl, longint'(release_step), 0);
          if (lvl == 0) begin ph = M_OFF; e_done = 1; end
        end
      end
      default: ph = M_OFF;
    endcase
    gprev = gate;
    e_act = (ph != M_OFF);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge lrclk);
    model_edge();
    #1;
    chk({tag, "_out"}, {8'h0, out}, 32'(lvl));
    chk({tag, "_active"}, {31'h0, active}, {31'h0, e_act});
    chk({tag, "_done"}, {31'h0, done}, {31'h0, e_done});
  endtask

  task automatic run_to_hold(input string tag);
    for (int i = 0; i < 64 && ph != M_HOLD; i++) tick(tag);
    chk({tag, "_reached"}, {31'h0, (ph == M_HOLD)}, 32'h1);
  endtask

  function automatic logic [23:0] rnd_step();
    case ($urandom_range(0, 4))
      0:       return 24'h0;
      1:       return 24'($urandom_range(1, 31));
      2:       return 24'($urandom_range(32'h10000, 32'h1FFFFF));
      3:       return 24'hFFFFFF - 24'($urandom_range(0, 255));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; gate = 1'b0;
    attack_step = 24'h100000; decay_step = 24'h080000;
    sustain_level = 24'h400000; release_step = 24'h180000;
    tick("rst0");
    tick("rst1");
    chk("rst_out", {8'h0, out}, 32'h0);

    // Linear attack then decay to sustain.
    reset = 1'b0; gate = 1'b1;
    tick("rise");
    chk("rise_out", {8'h0, out}, 32'h0);
    chk("rise_active", {31'h0, active}, 32'h1);
    for (int i = 1; i <= 7; i++) begin
      tick("atk");
      chk("atk_lit", {8'h0, out}, 32'(i) * 32'h100000);
    end
    tick("peak");
    chk("peak_lit", {8'h0, out}, 32'h7FFFFF);
`ifndef ADSR_EXP_RELEASE_EN
    for (int i = 1; i <= 7; i++) begin
      tick("dec");
      chk("dec_lit", {8'h0, out}, 32'h7FFFFF - 32'(i) * 32'h80000);
    end
    tick("dec_end");
    chk("dec_end_lit", {8'h0, out}, 32'h400000);
`endif
    run_to_hold("to_sus");
    repeat (3) tick("sus_hold");
    chk("sus_hold_lit", {8'h0, out}, 32'h400000);

    // Live sustain changes, including clamp.
    sustain_level = 24'h300000; tick("sus_chg");
    chk("sus_chg_lit", {8'h0, out}, 32'h300000);
    sustain_level = 24'hFFFFFF; tick("sus_clamp");
    chk("sus_clamp_lit", {8'h0, out}, 32'h7FFFFF);
    sustain_level = 24'h400000; tick("sus_back");

    // Reset mid-note, no done pulse.
    reset = 1'b1;
    tick("mid_rst0");
    tick("mid_rst1");
    chk("mid_rst_out", {8'h0, out}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    run_to_hold("re_sus");

    // Linear release with done pulse.
    gate = 1'b0;
    tick("rel_hold");
    chk("rel_hold_lit", {8'h0, out}, 32'h400000);
`ifndef ADSR_EXP_RELEASE_EN
    tick("rel1"); chk("rel1_lit", {8'h0, out}, 32'h280000);
    tick("rel2"); chk("rel2_lit", {8'h0, out}, 32'h100000);
    tick("rel3"); chk("rel3_lit", {8'h0, out}, 32'h0);
    chk("rel3_done", {31'h0, done}, 32'h1);
    chk("rel3_active", {31'h0, active}, 32'h0);
`endif
    for (int i = 0; i < 64 && ph != M_OFF; i++) tick("rel_wait");
    tick("post_rel");
    chk("post_rel_done", {31'h0, done}, 32'h0);

    // Retrigger from mid-release.
    gate = 1'b1;
    run_to_hold("rt_sus");
    gate = 1'b0; release_step = 24'h100000;
    tick("rt_fall");
`ifndef ADSR_EXP_RELEASE_EN
    tick("rt_r1");
    tick("rt_r2");
    chk("rt_r2_lit", {8'h0, out}, 32'h200000);
    gate = 1'b1;
    tick("rt_rise");
    chk("rt_rise_lit", {8'h0, out}, 32'h200000);
    tick("rt_atk");
    chk("rt_atk_lit", {8'h0, out}, 32'h300000);
`else
    tick("rt_r1");
    gate = 1'b1;
    tick("rt_rise");
    tick("rt_atk");
`endif

    // Zero steps: every ramp is a single-edge jump.
    gate = 1'b0; release_step = 24'h0;
    tick("z_fall");
    tick("z_off");
    chk("z_off_lit", {8'h0, out}, 32'h0);
    attack_step = 24'h0; decay_step = 24'h0; sustain_level = 24'h200000;
    gate = 1'b1;
    tick("z_rise");
    tick("z_atk"); chk("z_atk_lit", {8'h0, out}, 32'h7FFFFF);
    tick("z_dec"); chk("z_dec_lit", {8'h0, out}, 32'h200000);
    tick("z_sus");
    gate = 1'b0;
    tick("z_hold"); chk("z_hold_lit", {8'h0, out}, 32'h200000);
    tick("z_rel");  chk("z_rel_lit", {8'h0, out}, 32'h0);
    chk("z_rel_done", {31'h0, done}, 32'h1);

    // Sustain of zero stays active while gate is held.
    sustain_level = 24'h0; decay_step = 24'h300000; gate = 1'b1;
    repeat (10) tick("s0");
    chk("s0_out", {8'h0, out}, 32'h0);
    chk("s0_active", {31'h0, active}, 32'h1);
    gate = 1'b0;
    tick("s0_fall");
    tick("s0_rel");

`ifdef ADSR_EXP_RELEASE_EN
    // Exponential release with k = 1.
    sustain_level = 24'h400000; gate = 1'b1;
    run_to_hold("x_sus");
    gate = 1'b0; release_step = 24'h1;
    tick("x_hold");
    tick("x_r1"); chk("x_r1_lit", {8'h0, out}, 32'h1FFFFF);
    tick("x_r2"); chk("x_r2_lit", {8'h0, out}, 32'h0FFFFF);
    for (int i = 0; i < 64 && ph != M_OFF; i++) tick("x_wait");
    chk("x_idle", {31'h0, active}, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      if ($urandom_range(0, 31) == 0) attack_step = rnd_step();
      if ($urandom_range(0, 31) == 0) decay_step = rnd_step();
      if ($urandom_range(0, 31) == 0) release_step = rnd_step();
      if ($urandom_range(0, 31) == 0) sustain_level = 24'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
